// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises the RX pin, deframes LSB-first characters and
// strobes rx_ready for each good byte or rx_frame_err for a low stop bit.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       rx_serial,
    output logic [7:0] Rx_byte,
    output logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (Rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            Rx_byte      <= '0;
            rx_ready     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_ready     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt        <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit lets a start edge right after the stop bit be caught.
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            Rx_byte  <= shift;
                            rx_ready <= 1'b1;
                            state    <= IDLE;
                            rx_busy  <= 1'b0;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= BRK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: the stimulus queues each expected strobe,
// a negedge monitor pops and compares whenever the receiver strobes.
module tb_uart_rx_byte;

    localparam int unsigned P = 16;

    logic       clk;
    logic       Rst;
    logic       rx_serial;
    logic [7:0] Rx_byte;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx_byte #(.CLKS_PER_BIT(P)) dut (
        .clk          (clk),
        .Rst          (Rst),
        .rx_serial    (rx_serial),
        .Rx_byte      (Rx_byte),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    typedef struct {
        bit          err;
        logic [7:0]  data;
        int unsigned t0;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    logic [7:0]  model_byte = 8'h00;
    bit          rst_pend = 1'b0;
    bit          armed = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a strobe must match the oldest queued expectation, within ~9.5 bit times.
    always @(negedge clk) begin
        if (rst_pend) begin
            check("reset_rx_byte", Rx_byte, 0);
            check("reset_ready", rx_ready, 0);
            check("reset_frame_err", rx_frame_err, 0);
            check("reset_busy", rx_busy, 0);
            model_byte = 8'h00;
            armed = 1'b1;
        end else if (armed) begin
            if (rx_ready && rx_frame_err) begin
                checks++;
                errors++;
                $display("FAIL both_strobes: got ready=1 err=1 expected at most one");
            end
            if (rx_ready || rx_frame_err) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got ready=%0b err=%0b byte=%0h expected none",
                             rx_ready, rx_frame_err, Rx_byte);
                end else begin
                    mon_e = sb.pop_front();
                    check("strobe_kind_err", rx_frame_err, mon_e.err);
                    if (!mon_e.err) begin
                        check("rx_byte_on_ready", Rx_byte, mon_e.data);
                        model_byte = mon_e.data;
                    end else begin
                        check("rx_byte_kept_on_err", Rx_byte, model_byte);
                    end
                    checks++;
                    if (cyc - mon_e.t0 < 9 * P || cyc - mon_e.t0 > 10 * P + P / 2) begin
                        errors++;
                        $display("FAIL strobe_latency: got %0d cycles expected %0d..%0d",
                                 cyc - mon_e.t0, 9 * P, 10 * P + P / 2);
                    end
                end
            end
            check("rx_byte_hold", Rx_byte, model_byte);
        end
        rst_pend = Rst;
    end

    task automatic wait_cyc(input int unsigned n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int unsigned extra_low);
        exp_t e;
        e.err  = !stop_ok;
        e.data = b;
        e.t0   = cyc;
        sb.push_back(e);
        rx_serial = 1'b0;
        wait_cyc(P);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            wait_cyc(P);
        end
        if (stop_ok) begin
            rx_serial = 1'b1;
            wait_cyc(P);
        end else begin
            rx_serial = 1'b0;
            wait_cyc(P + extra_low);
            rx_serial = 1'b1;
            wait_cyc(2 * P);
        end
    endtask

    task automatic glitch(input int unsigned len);
        rx_serial = 1'b0;
        wait_cyc(len);
        rx_serial = 1'b1;
        wait_cyc(2 * P);
    endtask

    initial begin
        logic [7:0]  partial;
        int unsigned r;
        Rst = 1'b1;
        rx_serial = 1'b1;
        @(posedge clk);
        #1;
        wait_cyc(2);
        Rst = 1'b0;

        wait_cyc(100);
        check("idle_busy", rx_busy, 0);
        check("idle_rx_byte", Rx_byte, 0);

        send_frame(8'hA5, 1'b1, 0);
        wait_cyc(3 * P);

        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h5A, 1'b1, 0);
        wait_cyc(2 * P);

        send_frame(8'h3C, 1'b0, 40);
        send_frame(8'h11, 1'b1, 0);
        wait_cyc(2 * P);

        glitch(4);
        check("glitch_busy", rx_busy, 0);
        send_frame(8'h77, 1'b1, 0);
        wait_cyc(2 * P);

        // Abort 8'hC3 halfway through data bit 4; no expectation is queued for it.
        partial = 8'hC3;
        rx_serial = 1'b0;
        wait_cyc(P);
        for (int i = 0; i < 4; i++) begin
            rx_serial = partial[i];
            wait_cyc(P);
        end
        rx_serial = partial[4];
        wait_cyc(P / 2);
        Rst = 1'b1;
        wait_cyc(1);
        Rst = 1'b0;
        rx_serial = 1'b1;
        check("midreset_busy", rx_busy, 0);
        check("midreset_ready", rx_ready, 0);
        check("midreset_rx_byte", Rx_byte, 0);
        wait_cyc(3 * P);
        send_frame(8'h81, 1'b1, 0);
        wait_cyc(2 * P);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                glitch($urandom_range(1, 5));
            end else if (r == 1) begin
                send_frame(8'($urandom), 1'b0, $urandom_range(0, 40));
            end else begin
                send_frame(8'($urandom), 1'b1, 0);
                if ($urandom_range(0, 2) != 0) wait_cyc($urandom_range(1, 20));
            end
        end
        rx_serial = 1'b1;

        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: got %0d pending expected 0", sb.size());
        end
        wait_cyc(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
